// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the EX-stage execution unit: ALU control codes,
// FSM state encodings and the default datapath width.
package alu_exec_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned ALU_CONTROL_WIDTH  = 4;

  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_XOR = 4'd2;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND = 4'd4;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_LT  = 4'd7;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_JAL = 4'd8;

  typedef enum logic [1:0] {
    EXU_IDLE  = 2'd0,
    EXU_SHIFT = 2'd1,
    EXU_DONE  = 2'd2
  } exu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter. start loads the operand, count and
// direction; done_c flags the final step, when value_c holds the result.
module alu_shift_iter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   left,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   done_c,
  output logic [DATA_WIDTH-1:0]  value_c
);

  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   dir_left;

  // Next accumulator value: one-bit shift with zero fill
  assign value_c = dir_left ? {acc[DATA_WIDTH-2:0], 1'b0} : {1'b0, acc[DATA_WIDTH-1:1]};
  assign done_c  = (cnt == SHAMT_WIDTH'(1));

  // Load on start, then step until the counter drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else if (start) begin
      acc      <= data;
      cnt      <= shamt;
      dir_left <= left;
    end else if (cnt != '0) begin
      acc <= value_c;
      cnt <= cnt - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: valid/ready operand intake, registered result and
// zero flag held until the consumer takes them. Define ALU_FAST_SHIFT_EN for a
// single-cycle barrel shifter; otherwise shifts step one bit per cycle.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_ctl,
  input  logic [DATA_WIDTH-1:0]        in_a,
  input  logic [DATA_WIDTH-1:0]        in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        result,
  output logic                         zero
);

  exu_state_e             state;
  logic [DATA_WIDTH-1:0]  op_result_c;
  logic [SHAMT_WIDTH-1:0] shamt_c;

  assign shamt_c = in_b[SHAMT_WIDTH-1:0];

`ifndef ALU_FAST_SHIFT_EN
  logic                  shift_start_c;
  logic                  shift_done_c;
  logic [DATA_WIDTH-1:0] shift_value_c;

  assign shift_start_c = (state == EXU_IDLE) && in_valid && (shamt_c != '0) &&
                         ((alu_ctl == ALU_SLL) || (alu_ctl == ALU_SRL));

  alu_shift_iter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (shift_start_c),
    .left    (alu_ctl == ALU_SLL),
    .data    (in_a),
    .shamt   (shamt_c),
    .done_c  (shift_done_c),
    .value_c (shift_value_c)
  );
`endif

  // Single-cycle operation select; undefined codes yield zero
  always_comb begin
    op_result_c = '0;
    case (alu_ctl)
      ALU_ADD: op_result_c = in_a + in_b;
      ALU_SUB: op_result_c = in_a - in_b;
      ALU_XOR: op_result_c = in_a ^ in_b;
      ALU_OR:  op_result_c = in_a | in_b;
      ALU_AND: op_result_c = in_a & in_b;
      ALU_LT:  op_result_c = DATA_WIDTH'($signed(in_a) < $signed(in_b));
      ALU_JAL: op_result_c = in_a + DATA_WIDTH'(4);
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL: op_result_c = in_a << shamt_c;
      ALU_SRL: op_result_c = in_a >> shamt_c;
`else
      // Only reaches the result register when shamt is zero
      ALU_SLL: op_result_c = in_a;
      ALU_SRL: op_result_c = in_a;
`endif
      default: op_result_c = '0;
    endcase
  end

  // Control FSM with registered handshake outputs, result and zero flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EXU_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        EXU_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            if (shift_start_c) begin
              state <= EXU_SHIFT;
            end else
`endif
            begin
              result    <= op_result_c;
              zero      <= (op_result_c == '0);
              out_valid <= 1'b1;
              state     <= EXU_DONE;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        EXU_SHIFT: begin
          if (shift_done_c) begin
            result    <= shift_value_c;
            zero      <= (shift_value_c == '0);
            out_valid <= 1'b1;
            state     <= EXU_DONE;
          end
        end
`endif
        EXU_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= EXU_IDLE;
          end
        end
        default: begin
          state     <= EXU_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus backpressure and
// mid-shift reset sequences. Honours ALU_FAST_SHIFT_EN for expected latency.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic                         clk;
  logic                         rst;
  logic                         in_valid;
  logic                         in_ready;
  logic [ALU_CONTROL_WIDTH-1:0] alu_ctl;
  logic [31:0]                  in_a;
  logic [31:0]                  in_b;
  logic                         out_valid;
  logic                         out_ready;
  logic [31:0]                  result;
  logic                         zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ALU_CONTROL_WIDTH-1:0] ctl;
    logic [31:0]                  a;
    logic [31:0]                  b;
    logic [31:0]                  res;
    logic                         z;
    int                           lat_iter;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid; lat=1 means valid right after the accept edge
  task automatic run_op(input logic [ALU_CONTROL_WIDTH-1:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic z,
                        output int lat, output logic ready_low);
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctl  = ctl;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_a      = 32'hDEAD_BEEF;
    in_b      = 32'h0BAD_F00D;
    lat       = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    z   = zero;
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    int          lat;
    int          exp_lat;
    logic        rl;

    vecs[0]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
    vecs[1]  = '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1};
    vecs[2]  = '{ALU_LT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
    vecs[3]  = '{ALU_LT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
    vecs[4]  = '{ALU_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
    vecs[5]  = '{ALU_SRL, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1};
    vecs[6]  = '{ALU_JAL, 32'h0000_0100, 32'h0000_0000, 32'h0000_0104, 1'b0, 1};
    vecs[7]  = '{ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1};
    vecs[8]  = '{ALU_OR,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1};
    vecs[9]  = '{ALU_AND, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1'b0, 1};
    vecs[10] = '{ALU_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5};
    vecs[11] = '{ALU_SLL, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b0, 4};
    vecs[12] = '{4'hF,    32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1};
    vecs[13] = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[14] = '{ALU_SRL, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 1'b0, 32};
    vecs[15] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_ctl   = ALU_ADD;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result",    result,         32'd0);
    check("reset_zero",      32'(zero),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
`ifdef ALU_FAST_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = vecs[i].lat_iter;
`endif
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, r, z, lat, rl);
      check($sformatf("v%0d_result", i),  r,           vecs[i].res);
      check($sformatf("v%0d_zero", i),    32'(z),      32'(vecs[i].z));
      check($sformatf("v%0d_latency", i), 32'(lat),    32'(exp_lat));
      if (exp_lat > 1) check($sformatf("v%0d_busy_in_ready", i), 32'(rl), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_in_ready_after", i),  32'(in_ready),  32'd1);
      check($sformatf("v%0d_out_valid_after", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: result held, new in_valid ignored
    out_ready = 1'b0;
    run_op(ALU_ADD, 32'd2, 32'd3, r, z, lat, rl);
    check("bp_latency", 32'(lat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_ctl  = ALU_SUB;
      in_a     = 32'd9;
      in_b     = 32'd1;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_result", k),    result,          32'd5);
      check($sformatf("bp%0d_in_ready", k),  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_capture", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctl  = ALU_SRL;
    in_a     = 32'h8000_0000;
    in_b     = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result",    result,         32'd0);
    check("rst_mid_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(ALU_ADD, 32'd1, 32'd1, r, z, lat, rl);
    check("post_rst_result",  r,         32'd2);
    check("post_rst_latency", 32'(lat),  32'd1);
    check("post_rst_zero",    32'(z),    32'd0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
